// File: rtl/requant_relu.sv
// Requantizes eight 2W-bit dot_product accumulators to W-bit activations (bias, round, saturate, ReLU).
// Serial shared datapath: one element per cycle; out_v is sticky until start or rst.
module requant_relu #(
  parameter int                 W           = 16,
  parameter int                 FRAC        = 12,
  // Eight signed W-bit biases in Q(W-FRAC).FRAC; bias[i] lives in bits [i*W +: W].
  parameter logic [8*W-1:0]     BIAS_VALUES = '0,
  parameter bit                 RELU        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*W-1:0]   in_d0,
  input  logic [2*W-1:0]   in_d1,
  input  logic [2*W-1:0]   in_d2,
  input  logic [2*W-1:0]   in_d3,
  input  logic [2*W-1:0]   in_d4,
  input  logic [2*W-1:0]   in_d5,
  input  logic [2*W-1:0]   in_d6,
  input  logic [2*W-1:0]   in_d7,
  input  logic [7:0]       in_v,
  input  logic             start,
  output logic [W-1:0]     out_d0,
  output logic [W-1:0]     out_d1,
  output logic [W-1:0]     out_d2,
  output logic [W-1:0]     out_d3,
  output logic [W-1:0]     out_d4,
  output logic [W-1:0]     out_d5,
  output logic [W-1:0]     out_d6,
  output logic [W-1:0]     out_d7,
  output logic             out_v
);

  localparam int AW = 2*W + 2;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] RND     = AW'(1) <<< (FRAC-1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_idx, w_idx_nxt;
  logic [W-1:0]   r_out [8];
  logic           r_out_v;
  logic           w_wr_en;
  logic           w_set_v;
  logic           w_clr_v;

  logic [2*W-1:0]        w_in;
  logic [W-1:0]          w_bias;
  logic signed [AW-1:0]  w_in_ext;
  logic signed [AW-1:0]  w_bias_ext;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shr;
  logic [W-1:0]          w_sat;
  logic [W-1:0]          w_res;

  always_comb begin
    w_in = '0;
    case (r_idx)
      3'd0: w_in = in_d0;
      3'd1: w_in = in_d1;
      3'd2: w_in = in_d2;
      3'd3: w_in = in_d3;
      3'd4: w_in = in_d4;
      3'd5: w_in = in_d5;
      3'd6: w_in = in_d6;
      default: w_in = in_d7;
    endcase
  end

  assign w_bias     = BIAS_VALUES[r_idx*W +: W];
  assign w_in_ext   = {{2{w_in[2*W-1]}}, w_in};
  assign w_bias_ext = {{(AW-W){w_bias[W-1]}}, w_bias};
  // Two guard bits keep the bias and rounding adds from wrapping before saturation.
  assign w_sum      = w_in_ext + (w_bias_ext <<< FRAC) + RND;
  assign w_shr      = w_sum >>> FRAC;

  always_comb begin
    w_sat = w_shr[W-1:0];
    if (w_shr > SAT_MAX) w_sat = SAT_MAX[W-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[W-1:0];
  end

  assign w_res = (RELU && w_sat[W-1]) ? '0 : w_sat;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_set_v     = 1'b0;
    w_clr_v     = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (in_v == 8'hFF) begin
          w_state_nxt = ST_PROC;
          w_idx_nxt   = 3'd0;
        end
      end
      ST_PROC: begin
        w_wr_en   = 1'b1;
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          w_state_nxt = ST_DONE;
          w_set_v     = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WAIT;
          w_clr_v     = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT;
      r_idx   <= 3'd0;
      r_out_v <= 1'b0;
      for (int i = 0; i < 8; i++) r_out[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_set_v) r_out_v <= 1'b1;
      else if (w_clr_v) r_out_v <= 1'b0;
      if (w_wr_en) r_out[r_idx] <= w_res;
    end
  end

  assign out_d0 = r_out[0];
  assign out_d1 = r_out[1];
  assign out_d2 = r_out[2];
  assign out_d3 = r_out[3];
  assign out_d4 = r_out[4];
  assign out_d5 = r_out[5];
  assign out_d6 = r_out[6];
  assign out_d7 = r_out[7];
  assign out_v  = r_out_v;

endmodule
